// File: rtl/hyper_xface.sv
// HyperBus master: serialises CA, waits the initial latency and moves 32-bit dwords to/from one HyperRAM.
// Every bus edge takes two clk cycles: phase A drives DQ/RWDS, phase B toggles CK.
module hyper_xface #(
  parameter int LATENCY_1X = 16,
  parameter int LATENCY_2X = 22
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic        mem_or_req,
  input  logic [3:0]  wr_byte_en,
  input  logic [5:0]  rd_num_dwords,
  input  logic [31:0] addr,
  input  logic [31:0] wr_d,
  output logic [31:0] rd_d,
  output logic        rd_rdy,
  output logic        busy,
  output logic        burst_wr_rdy,
  input  logic [7:0]  dram_dq_in,
  output logic [7:0]  dram_dq_out,
  output logic        dram_dq_oe_l,
  input  logic        dram_rwds_in,
  output logic        dram_rwds_out,
  output logic        dram_rwds_oe_l,
  output logic        dram_ck,
  output logic        dram_rst_l,
  output logic        dram_cs_l
);

  // state  | meaning
  // IDLE   | waiting for a request
  // CA     | six command/address edges
  // LAT    | initial access latency edges
  // WDATA  | write bytes (4 memory, 2 register)
  // RDATA  | read capture on RWDS toggles
  // END    | park CK low, then deselect
  // RECOV  | two-cycle recovery before IDLE
  typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_WDATA, S_RDATA, S_END, S_RECOV} state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic [47:0] ca_q, ca_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic        is_wr_q, is_wr_d, is_reg_q, is_reg_d;
  logic [5:0]  ndw_q, ndw_d, tmo_q, tmo_d;
  logic        rwds_hi_q, rwds_hi_d, rwds_r_q, rwds_p_q, rwds_tgl;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] rd_d_q, rd_d_d;
  logic        rd_rdy_q, rd_rdy_d;
  logic [7:0]  dq_out_q, dq_out_d;
  logic        rwds_out_q, rwds_out_d, dq_oe_l_q, dq_oe_l_d, rwds_oe_l_q, rwds_oe_l_d;
  logic        ck_q, ck_d, cs_l_q, cs_l_d, rst_q;

  assign rwds_tgl = rwds_r_q ^ rwds_p_q;

  always_ff @(posedge clk) begin
    if (!reset_l) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;  phase_d = phase_q;  ecnt_d = ecnt_q;  ca_d = ca_q;  wd_d = wd_q;
    be_d = be_q;  is_wr_d = is_wr_q;  is_reg_d = is_reg_q;  ndw_d = ndw_q;  tmo_d = tmo_q;
    rwds_hi_d = rwds_hi_q;  bcnt_d = bcnt_q;  shift_d = shift_q;  rd_d_d = rd_d_q;  rd_rdy_d = 1'b0;
    dq_out_d = dq_out_q;  rwds_out_d = rwds_out_q;  dq_oe_l_d = dq_oe_l_q;  rwds_oe_l_d = rwds_oe_l_q;
    ck_d = ck_q;  cs_l_d = cs_l_q;
    unique case (state_q)
      S_IDLE: if (wr_req || rd_req) begin
        is_wr_d   = wr_req;
        is_reg_d  = mem_or_req;
        ca_d      = {~wr_req, mem_or_req, 1'b1, addr[31:3], 13'd0, addr[2:0]};
        wd_d      = mem_or_req ? {wr_d[15:0], 16'd0} : wr_d;  // register writes carry only the low half
        be_d      = wr_byte_en;
        ndw_d     = (rd_num_dwords == 6'd0) ? 6'd0 : rd_num_dwords - 6'd1;
        rwds_hi_d = 1'b0;
        phase_d   = 1'b0;
        ecnt_d    = 8'd5;
        state_d   = S_CA;
      end
      S_CA: if (!phase_q) begin
        dq_out_d  = ca_q[47:40];
        ca_d      = {ca_q[39:0], 8'h00};
        cs_l_d    = 1'b0;
        dq_oe_l_d = 1'b0;
        phase_d   = 1'b1;
      end else begin
        ck_d      = ~ck_q;
        phase_d   = 1'b0;
        ecnt_d    = ecnt_q - 8'd1;
        rwds_hi_d = rwds_hi_q | dram_rwds_in;
        if (ecnt_q == 8'd0) begin
          if (is_wr_q && is_reg_q) begin
            state_d = S_WDATA;
            ecnt_d  = 8'd1;
          end else begin
            state_d = S_LAT;
            ecnt_d  = (rwds_hi_q | dram_rwds_in) ? 8'(LATENCY_2X - 1) : 8'(LATENCY_1X - 1);
          end
        end
      end
      S_LAT: if (!phase_q) begin
        if (!is_wr_q) dq_oe_l_d = 1'b1;
        phase_d = 1'b1;
      end else begin
        ck_d    = ~ck_q;
        phase_d = 1'b0;
        ecnt_d  = ecnt_q - 8'd1;
        if (ecnt_q == 8'd0) begin
          if (is_wr_q) begin
            state_d = S_WDATA;
            ecnt_d  = 8'd3;
          end else begin
            state_d = S_RDATA;
            tmo_d   = 6'd63;
            bcnt_d  = 2'd0;
          end
        end
      end
      S_WDATA: if (!phase_q) begin
        dq_out_d = wd_q[31:24];
        wd_d     = {wd_q[23:0], 8'h00};
        phase_d  = 1'b1;
        if (!is_reg_q) begin
          rwds_oe_l_d = 1'b0;
          rwds_out_d  = ~be_q[3];
          be_d        = {be_q[2:0], 1'b0};
        end
      end else begin
        ck_d    = ~ck_q;
        phase_d = 1'b0;
        ecnt_d  = ecnt_q - 8'd1;
        if (ecnt_q == 8'd0) state_d = S_END;
      end
      S_RDATA: begin
        phase_d = ~phase_q;
        if (phase_q) ck_d = ~ck_q;
        if (rwds_tgl) begin
          shift_d = {shift_q[15:0], dram_dq_in};
          bcnt_d  = bcnt_q + 2'd1;
          tmo_d   = 6'd63;
          if (bcnt_q == 2'd3) begin
            rd_d_d   = {shift_q, dram_dq_in};
            rd_rdy_d = 1'b1;
            if (ndw_q == 6'd0) state_d = S_END;
            else               ndw_d = ndw_q - 6'd1;
          end
        end else if (tmo_q == 6'd0) begin
          state_d = S_END;
        end else begin
          tmo_d = tmo_q - 6'd1;
        end
      end
      S_END: if (!phase_q && !ck_q) begin
        cs_l_d      = 1'b1;
        dq_oe_l_d   = 1'b1;
        rwds_oe_l_d = 1'b1;
        dq_out_d    = 8'h00;
        rwds_out_d  = 1'b0;
        ecnt_d      = 8'd1;
        state_d     = S_RECOV;
      end else begin
        // finish a half-done edge so CK always parks low
        phase_d = ~phase_q;
        if (phase_q) ck_d = 1'b0;
      end
      S_RECOV: if (ecnt_q == 8'd0) state_d = S_IDLE;
               else                ecnt_d = ecnt_q - 8'd1;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != S_IDLE);
    burst_wr_rdy   = 1'b0;
    rd_d           = rd_d_q;
    rd_rdy         = rd_rdy_q;
    dram_dq_out    = dq_out_q;
    dram_dq_oe_l   = dq_oe_l_q;
    dram_rwds_out  = rwds_out_q;
    dram_rwds_oe_l = rwds_oe_l_q;
    dram_ck        = ck_q;
    dram_cs_l      = cs_l_q;
    dram_rst_l     = rst_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      phase_q <= 1'b0;  ecnt_q <= 8'd0;  ca_q <= 48'd0;  wd_q <= 32'd0;  be_q <= 4'd0;
      is_wr_q <= 1'b0;  is_reg_q <= 1'b0;  ndw_q <= 6'd0;  tmo_q <= 6'd0;  rwds_hi_q <= 1'b0;
      rwds_r_q <= 1'b0;  rwds_p_q <= 1'b0;  bcnt_q <= 2'd0;  shift_q <= 24'd0;
      rd_d_q <= 32'd0;  rd_rdy_q <= 1'b0;  dq_out_q <= 8'h00;  rwds_out_q <= 1'b0;
      dq_oe_l_q <= 1'b1;  rwds_oe_l_q <= 1'b1;  ck_q <= 1'b0;  cs_l_q <= 1'b1;  rst_q <= 1'b0;
    end else begin
      phase_q <= phase_d;  ecnt_q <= ecnt_d;  ca_q <= ca_d;  wd_q <= wd_d;  be_q <= be_d;
      is_wr_q <= is_wr_d;  is_reg_q <= is_reg_d;  ndw_q <= ndw_d;  tmo_q <= tmo_d;  rwds_hi_q <= rwds_hi_d;
      rwds_r_q <= dram_rwds_in;  rwds_p_q <= rwds_r_q;  bcnt_q <= bcnt_d;  shift_q <= shift_d;
      rd_d_q <= rd_d_d;  rd_rdy_q <= rd_rdy_d;  dq_out_q <= dq_out_d;  rwds_out_q <= rwds_out_d;
      dq_oe_l_q <= dq_oe_l_d;  rwds_oe_l_q <= rwds_oe_l_d;  ck_q <= ck_d;  cs_l_q <= cs_l_d;  rst_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hyper_xface.sv
// Bench for hyper_xface: a behavioural HyperRAM on the pins plus a byte-level reference memory.
module tb_hyper_xface;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_l, rd_req, wr_req, mem_or_req;
  logic [3:0]  wr_byte_en;
  logic [5:0]  rd_num_dwords;
  logic [31:0] addr, wr_d, rd_d;
  logic        rd_rdy, busy, burst_wr_rdy;
  logic [7:0]  dram_dq_in = 8'h00, dram_dq_out;
  logic        dram_dq_oe_l, dram_rwds_in = 1'b0, dram_rwds_out, dram_rwds_oe_l;
  logic        dram_ck, dram_rst_l, dram_cs_l;

  hyper_xface dut (
    .clk(clk), .reset_l(reset_l), .rd_req(rd_req), .wr_req(wr_req), .mem_or_req(mem_or_req),
    .wr_byte_en(wr_byte_en), .rd_num_dwords(rd_num_dwords), .addr(addr), .wr_d(wr_d),
    .rd_d(rd_d), .rd_rdy(rd_rdy), .busy(busy), .burst_wr_rdy(burst_wr_rdy),
    .dram_dq_in(dram_dq_in), .dram_dq_out(dram_dq_out), .dram_dq_oe_l(dram_dq_oe_l),
    .dram_rwds_in(dram_rwds_in), .dram_rwds_out(dram_rwds_out), .dram_rwds_oe_l(dram_rwds_oe_l),
    .dram_ck(dram_ck), .dram_rst_l(dram_rst_l), .dram_cs_l(dram_cs_l)
  );

  int compared = 0, mismatched = 0;

  // pin-level device model state
  bit          dev_lat2 = 1'b0, dev_mute = 1'b0;
  int          edge_i = 0, dj, dev_base, last_edges, cs_falls = 0, rdy_cnt = 0;
  logic        prev_ck = 1'b0, prev_cs = 1'b1, busy_gap = 1'b0, dev_is_rd, dev_space;
  logic [47:0] ca_sh = '0;
  logic [7:0]  tx_b[$];
  logic [1:0]  tx_rw[$];
  logic [31:0] rd_q[$];
  bit   [7:0]  dev_mem[int];
  bit   [7:0]  ref_mem[int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dev_rd(int k);
    return dev_mem.exists(k) ? dev_mem[k] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(int k);
    return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
  endfunction

  function automatic logic [7:0] q_at(int i);
    return (i < tx_b.size()) ? tx_b[i] : 8'hxx;
  endfunction

  function automatic logic [1:0] rw_at(int i);
    return (i < tx_rw.size()) ? tx_rw[i] : 2'bxx;
  endfunction

  // HyperRAM behaviour: decode CA, store unmasked write bytes, answer reads with an RWDS toggle per edge
  always @(negedge clk) begin
    if (prev_cs && !dram_cs_l) cs_falls++;
    prev_cs = dram_cs_l;
    if (dram_cs_l) begin
      if (edge_i != 0) last_edges = edge_i;
      edge_i       = 0;
      dram_rwds_in = dev_lat2;
      dram_dq_in   = 8'h00;
    end else begin
      if (busy !== 1'b1) busy_gap = 1'b1;
      if (dram_ck !== prev_ck) begin
        tx_b.push_back(dram_dq_out);
        tx_rw.push_back({dram_rwds_oe_l, dram_rwds_out});
        if (edge_i < 6) ca_sh = {ca_sh[39:0], dram_dq_out};
        if (edge_i == 5) begin
          dev_is_rd    = ca_sh[47];
          dev_space    = ca_sh[46];
          dev_base     = 2 * int'({ca_sh[44:16], ca_sh[2:0]});
          dram_rwds_in = 1'b0;
        end
        dj = (dev_space && !dev_is_rd) ? edge_i - 6 : edge_i - 6 - (dev_lat2 ? 22 : 16);
        if (edge_i >= 6 && dj >= 0) begin
          if (dev_is_rd) begin
            if (!dev_mute) begin
              dram_dq_in   = dev_rd(dev_base + dj);
              dram_rwds_in = ~dram_rwds_in;
            end
          end else if (!dev_space && dj < 4 && dram_rwds_out == 1'b0) begin
            dev_mem[dev_base + dj] = dram_dq_out;
          end
        end
        edge_i++;
      end
    end
    prev_ck = dram_ck;
  end

  always @(negedge clk) if (rd_rdy === 1'b1) begin
    rdy_cnt++;
    rd_q.push_back(rd_d);
  end

  task automatic check_ca(input bit rd, input bit space, input logic [31:0] a);
    logic [47:0] got, exp;
    got = '0;
    for (int i = 0; i < 6; i++) got = (got << 8) | 48'(q_at(i));
    exp = (48'(rd) << 47) + (48'(space) << 46) + (48'd1 << 45) + (48'(a >> 3) << 16) + 48'(a % 8);
    check("ca", got, exp);
  endtask

  task automatic do_txn(input bit rd, input bit wr, input bit space, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic [5:0] n, input bit poke);
    int t, lat, nd, c0, first, nb;
    logic [31:0] exp;
    tx_b.delete(); tx_rw.delete(); rd_q.delete();
    rdy_cnt = 0; busy_gap = 1'b0; last_edges = -1; c0 = cs_falls;
    lat = dev_lat2 ? 22 : 16;
    rd_req = rd; wr_req = wr; mem_or_req = space; addr = a; wr_d = d; wr_byte_en = be; rd_num_dwords = n;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0; addr = $urandom; wr_d = $urandom;
    wr_byte_en = 4'($urandom); rd_num_dwords = 6'($urandom); mem_or_req = 1'($urandom);
    check("busy_rise", busy, 1'b1);
    if (poke) begin
      repeat (4) @(negedge clk);
      rd_req = 1'b1; wr_req = 1'b1;
      repeat (2) @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
    end
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin @(negedge clk); t++; end
    check("busy_fall", busy, 1'b0);
    check("ck_parked", dram_ck, 1'b0);
    check("busy_during_cs", busy_gap, 1'b0);
    check("edges_even", 64'(last_edges % 2), 64'd0);
    check_ca(!wr, space, a);
    if (wr) begin
      first = space ? 6 : 6 + lat;
      nb    = space ? 2 : 4;
      check("wr_edges", 64'(last_edges), 64'(first + nb));
      for (int j = 0; j < nb; j++) begin
        check("wr_byte", q_at(first + j), 8'(d >> (8 * (nb - 1 - j))));
        if (space) check("reg_rwds_oe", rw_at(first + j) >> 1, 2'd1);
        else       check("wr_rwds", rw_at(first + j), {1'b0, ~be[3 - j]});
        if (!space && be[3 - j]) ref_mem[2 * int'(a) + j] = 8'(d >> (24 - 8 * j));
      end
    end else begin
      nd = (n == 6'd0) ? 1 : int'(n);
      check("rdy_pulses", 64'(rdy_cnt), dev_mute ? 64'd0 : 64'(nd));
      for (int k = 0; k < nd && k < rd_q.size(); k++) begin
        exp = '0;
        for (int j = 0; j < 4; j++) exp = (exp << 8) | 32'(ref_rd(2 * int'(a) + 4 * k + j));
        check("rd_d", rd_q[k], exp);
      end
    end
    repeat (6) @(negedge clk);
    check("one_cs_frame", 64'(cs_falls - c0), 64'd1);
  endtask

  initial begin
    int t;
    reset_l = 1'b0; rd_req = 1'b0; wr_req = 1'b0; mem_or_req = 1'b0; wr_byte_en = 4'h0;
    rd_num_dwords = 6'd0; addr = '0; wr_d = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_cs_l", dram_cs_l, 1'b1);
    check("rst_ck", dram_ck, 1'b0);
    check("rst_dq_oe_l", dram_dq_oe_l, 1'b1);
    check("rst_rwds_oe_l", dram_rwds_oe_l, 1'b1);
    check("rst_dram_rst_l", dram_rst_l, 1'b0);
    check("rst_rd_rdy", rd_rdy, 1'b0);
    check("rst_rd_d", rd_d, 32'd0);
    check("burst_wr_rdy", burst_wr_rdy, 1'b0);
    reset_l = 1'b1;
    @(negedge clk);
    check("dram_rst_release", dram_rst_l, 1'b1);

    dev_lat2 = 1'b0;
    do_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 6'd0, 1'b0);
    dev_lat2 = 1'b1;
    do_txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 6'd1, 1'b0);
    dev_lat2 = 1'b0;
    do_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h11223344, 4'b0101, 6'd0, 1'b0);
    do_txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 6'd1, 1'b0);

    // simultaneous requests: write wins; requests while busy are dropped
    dev_lat2 = 1'b1;
    do_txn(1'b1, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D, 4'hF, 6'd3, 1'b1);
    do_txn(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 6'd2, 1'b0);

    dev_lat2 = 1'b0;
    do_txn(1'b0, 1'b1, 1'b1, 32'h800, 32'h1234ABCD, 4'hF, 6'd0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      dev_lat2 = 1'($urandom);
      if ($urandom_range(0, 1) == 0)
        do_txn(1'b0, 1'b1, 1'b0, 32'($urandom_range(0, 40)), $urandom, 4'($urandom), 6'd0, 1'b0);
      else
        do_txn(1'b1, 1'b0, 1'b0, 32'($urandom_range(0, 40)), 32'h0, 4'h0, 6'($urandom_range(0, 3)), 1'b0);
    end

    dev_mute = 1'b1;
    do_txn(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 6'd1, 1'b0);
    dev_mute = 1'b0;

    // reset in the middle of the latency window
    rdy_cnt = 0;
    rd_req = 1'b1; addr = 32'h10; rd_num_dwords = 6'd1;
    @(negedge clk);
    rd_req = 1'b0;
    t = 0;
    while (edge_i < 10 && t < 500) begin @(negedge clk); t++; end
    check("reached_lat", 64'(edge_i >= 10), 64'd1);
    reset_l = 1'b0;
    @(negedge clk);
    check("midrst_cs_l", dram_cs_l, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ck", dram_ck, 1'b0);
    check("midrst_dq_oe_l", dram_dq_oe_l, 1'b1);
    reset_l = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_no_rdy", 64'(rdy_cnt), 64'd0);
    check("midrst_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
